// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS execute-stage branch resolution slice.
package mips_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    SQUASH
  } state_e;

  localparam logic [1:0] PHT_RESET = 2'b01;
  localparam logic [1:0] PHT_MAX   = 2'b11;
  localparam logic [1:0] PHT_MIN   = 2'b00;

  // Saturating 2-bit counter step.
  function automatic logic [1:0] pht_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == PHT_MAX) ? PHT_MAX : cnt + 2'd1;
    else       return (cnt == PHT_MIN) ? PHT_MIN : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/mips_branch_resolve_if.sv
// Execute-to-fetch branch resolution bus. BRANCH_STATS_EN adds the statistics outputs.
interface mips_branch_resolve_if #(
  parameter int INDEX_W = 4
);
  import mips_pkg::*;

  logic              Valid;
  logic              Branch;
  logic [WORD_W-1:0] NextPc;
  logic [WORD_W-1:0] SignExtendedImmediate;
  logic [WORD_W-1:0] ReadDataOne;
  logic [WORD_W-1:0] ReadDataTwo;
  logic              Hit;
  logic              PcSource;
  logic [WORD_W-1:0] BranchTarget;
  logic              Flush;
  logic              UpdateValid;
  logic [INDEX_W-1:0] UpdateIndex;
  logic              UpdateTaken;
`ifdef BRANCH_STATS_EN
  logic [WORD_W-1:0] BranchCount;
  logic [WORD_W-1:0] MispredictCount;
`endif

  modport master (
    output Valid, Branch, NextPc, SignExtendedImmediate, ReadDataOne, ReadDataTwo, Hit,
`ifdef BRANCH_STATS_EN
    input  BranchCount, MispredictCount,
`endif
    input  PcSource, BranchTarget, Flush, UpdateValid, UpdateIndex, UpdateTaken
  );

  modport slave (
    input  Valid, Branch, NextPc, SignExtendedImmediate, ReadDataOne, ReadDataTwo, Hit,
`ifdef BRANCH_STATS_EN
    output BranchCount, MispredictCount,
`endif
    output PcSource, BranchTarget, Flush, UpdateValid, UpdateIndex, UpdateTaken
  );

endinterface

// File: rtl/mips_pht.sv
// 2-bit saturating pattern history table with a one-deep registered write and read bypass.
module mips_pht
  import mips_pkg::*;
#(
  parameter int PHT_ENTRIES = 16,
  parameter int INDEX_W     = $clog2(PHT_ENTRIES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_idx,
  input  logic               upd_en,
  input  logic               taken,
  output logic [1:0]         cnt_new
);

  logic [PHT_ENTRIES-1:0][1:0] cnt_q;
  logic                        wr_en;
  logic [INDEX_W-1:0]          wr_idx;
  logic [1:0]                  wr_cnt;
  logic [1:0]                  rd_cnt;

  // The array write lands one edge after resolution; bypass so a back-to-back
  // branch on the same index sees the fresh counter.
  always_comb begin
    rd_cnt  = cnt_q[rd_idx];
    if (wr_en && (wr_idx == rd_idx)) rd_cnt = wr_cnt;
    cnt_new = pht_next(rd_cnt, taken);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= {PHT_ENTRIES{PHT_RESET}};
      wr_en  <= 1'b0;
      wr_idx <= '0;
      wr_cnt <= PHT_RESET;
    end else begin
      wr_en <= upd_en;
      if (upd_en) begin
        wr_idx <= rd_idx;
        wr_cnt <= cnt_new;
      end
      if (wr_en) cnt_q[wr_idx] <= wr_cnt;
    end
  end

endmodule

// File: rtl/mips_branch_resolve.sv
// Execute-stage beq resolution: target calc, mispredict redirect + 2-cycle squash, PHT update.
// Optional statistics counters under BRANCH_STATS_EN.
module mips_branch_resolve
  import mips_pkg::*;
#(
  parameter  int PHT_ENTRIES = 16,
  localparam int INDEX_W     = $clog2(PHT_ENTRIES)
) (
  input  logic             ClockPulse,
  input  logic             Reset,
  mips_branch_resolve_if.slave br
);

  state_e             state, state_nxt;
  logic               resolve;
  logic               taken;
  logic               mispredict;
  logic [WORD_W-1:0]  target;
  logic [INDEX_W-1:0] idx;
  logic [1:0]         cnt_new;

  // Anything arriving outside IDLE is wrong-path and dropped.
  assign resolve    = br.Valid & br.Branch & (state == IDLE);
  assign target     = br.NextPc + (br.SignExtendedImmediate << 2);
  assign taken      = (br.ReadDataOne == br.ReadDataTwo);
  assign mispredict = taken ^ br.Hit;
  assign idx        = br.NextPc[INDEX_W+1:2];

  mips_pht #(
    .PHT_ENTRIES (PHT_ENTRIES),
    .INDEX_W     (INDEX_W)
  ) u_pht (
    .clk     (ClockPulse),
    .rst     (Reset),
    .rd_idx  (idx),
    .upd_en  (resolve),
    .taken   (taken),
    .cnt_new (cnt_new)
  );

  always_ff @(posedge ClockPulse) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    br.PcSource = 1'b0;
    br.Flush    = 1'b0;
    case (state)
      IDLE:     if (resolve && mispredict) state_nxt = REDIRECT;
      REDIRECT: begin
        br.PcSource = 1'b1;
        br.Flush    = 1'b1;
        state_nxt   = SQUASH;
      end
      SQUASH: begin
        br.Flush  = 1'b1;
        state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ClockPulse) begin
    if (Reset) begin
      br.BranchTarget <= '0;
      br.UpdateValid  <= 1'b0;
      br.UpdateIndex  <= '0;
      br.UpdateTaken  <= 1'b0;
    end else begin
      br.UpdateValid <= resolve;
      if (resolve) begin
        br.BranchTarget <= taken ? target : br.NextPc;
        br.UpdateIndex  <= idx;
        br.UpdateTaken  <= cnt_new[1];
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge ClockPulse) begin
    if (Reset) begin
      br.BranchCount     <= '0;
      br.MispredictCount <= '0;
    end else if (resolve) begin
      br.BranchCount <= br.BranchCount + 32'd1;
      if (mispredict) br.MispredictCount <= br.MispredictCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_branch_resolve.sv
// Directed bench for mips_branch_resolve with hand-computed expectations.
module tb_mips_branch_resolve;
  import mips_pkg::*;

  logic ClockPulse = 1'b0;
  logic Reset;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 ClockPulse = ~ClockPulse;

  mips_branch_resolve_if #(.INDEX_W(4)) br ();

  mips_branch_resolve #(.PHT_ENTRIES(16)) dut (
    .ClockPulse (ClockPulse),
    .Reset      (Reset),
    .br         (br)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ps, input logic fl, input logic uv);
    chk({tag, ".PcSource"},    32'(br.PcSource),    32'(ps));
    chk({tag, ".Flush"},       32'(br.Flush),       32'(fl));
    chk({tag, ".UpdateValid"}, 32'(br.UpdateValid), 32'(uv));
  endtask

  task automatic tick;
    @(posedge ClockPulse);
    #1;
  endtask

  task automatic drv(input logic v, input logic [31:0] npc, input logic [31:0] imm,
                     input logic [31:0] a, input logic [31:0] b, input logic hit);
    br.Valid                 = v;
    br.Branch                = v;
    br.NextPc                = npc;
    br.SignExtendedImmediate = imm;
    br.ReadDataOne           = a;
    br.ReadDataTwo           = b;
    br.Hit                   = hit;
  endtask

  initial begin
    logic [5:0] ut_exp;
    Reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    tick;
    tick;
    chk_out("rst", 0, 0, 0);
    chk("rst.BranchTarget", br.BranchTarget, 32'h0);
    chk("rst.UpdateIndex",  32'(br.UpdateIndex), 32'h0);
    chk("rst.UpdateTaken",  32'(br.UpdateTaken), 32'h0);
    Reset = 1'b0;

    // Taken, predicted not-taken: redirect to target, counter 01->10.
    drv(1, 32'h100, 32'h4, 32'h5, 32'h5, 0);
    tick;
    drv(0, 0, 0, 0, 0, 0);
    chk_out("t1.n1", 1, 1, 1);
    chk("t1.BranchTarget", br.BranchTarget, 32'h110);
    chk("t1.UpdateIndex",  32'(br.UpdateIndex), 32'h0);
    chk("t1.UpdateTaken",  32'(br.UpdateTaken), 32'h1);
    tick;
    chk_out("t1.n2", 0, 1, 0);
    tick;
    chk_out("t1.n3", 0, 0, 0);

    // Not taken, predicted taken: fall-through repair, counter 01->00.
    drv(1, 32'h204, 32'h8, 32'h1, 32'h2, 1);
    tick;
    drv(0, 0, 0, 0, 0, 0);
    chk_out("t2.n1", 1, 1, 1);
    chk("t2.BranchTarget", br.BranchTarget, 32'h204);
    chk("t2.UpdateIndex",  32'(br.UpdateIndex), 32'h1);
    chk("t2.UpdateTaken",  32'(br.UpdateTaken), 32'h0);
    tick;
    tick;

    // Six back-to-back correct predictions on index 2: four taken (01->10->11->11->11)
    // then two not-taken (11->10->01).
    ut_exp = 6'b011111;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drv(1, 32'h108, 32'h10, 32'h7, 32'h7, 1);
      else       drv(1, 32'h108, 32'h10, 32'h7, 32'h8, 0);
      tick;
      chk_out($sformatf("t3.k%0d", k), 0, 0, 1);
      chk($sformatf("t3.k%0d.UpdateTaken", k), 32'(br.UpdateTaken), 32'(ut_exp[k]));
    end
    drv(0, 0, 0, 0, 0, 0);
    tick;
    chk_out("t3.end", 0, 0, 0);

    // Target arithmetic wraps silently.
    drv(1, 32'hFFFF_FFFC, 32'h1, 32'h3, 32'h3, 0);
    tick;
    drv(0, 0, 0, 0, 0, 0);
    chk("t4.BranchTarget", br.BranchTarget, 32'h0);
    chk("t4.PcSource",     32'(br.PcSource), 32'h1);
    chk("t4.UpdateIndex",  32'(br.UpdateIndex), 32'hF);
    chk("t4.UpdateTaken",  32'(br.UpdateTaken), 32'h1);
    tick;
    tick;

    // Mispredict then branches on every following cycle: two are dropped, the third resolves.
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    drv(1, 32'h300, 32'h2, 32'h9, 32'h9, 0);
    tick;
    drv(1, 32'h304, 32'h0, 32'h4, 32'h4, 1);
    chk_out("t5.n1", 1, 1, 1);
    tick;
    chk_out("t5.n2", 0, 1, 0);
    tick;
    chk_out("t5.n3", 0, 0, 0);
    tick;
    drv(0, 0, 0, 0, 0, 0);
    chk_out("t5.n4", 0, 0, 1);
    chk("t5.UpdateIndex", 32'(br.UpdateIndex), 32'h1);
    chk("t5.UpdateTaken", 32'(br.UpdateTaken), 32'h1);
`ifdef BRANCH_STATS_EN
    chk("t5.BranchCount",     br.BranchCount,     32'd2);
    chk("t5.MispredictCount", br.MispredictCount, 32'd1);
`endif

    // Reset during SQUASH aborts the squash and restores every counter to 01.
    drv(1, 32'h300, 32'h0, 32'h1, 32'h1, 0);
    tick;
    drv(0, 0, 0, 0, 0, 0);
    chk_out("t6.redirect", 1, 1, 1);
    tick;
    chk_out("t6.squash", 0, 1, 0);
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    chk_out("t6.rst", 0, 0, 0);
    chk("t6.BranchTarget", br.BranchTarget, 32'h0);
    chk("t6.state", 32'(dut.state), 32'(IDLE));
`ifdef BRANCH_STATS_EN
    chk("t6.BranchCount", br.BranchCount, 32'd0);
`endif
    drv(1, 32'h100, 32'h0, 32'h6, 32'h6, 1);
    tick;
    chk_out("t6.p0a", 0, 0, 1);
    chk("t6.p0a.UpdateTaken", 32'(br.UpdateTaken), 32'h1);
    drv(1, 32'h100, 32'h0, 32'h6, 32'h7, 0);
    tick;
    chk_out("t6.p0b", 0, 0, 1);
    chk("t6.p0b.UpdateTaken", 32'(br.UpdateTaken), 32'h0);
    drv(1, 32'h13C, 32'h0, 32'h6, 32'h6, 1);
    tick;
    chk("t6.p15a.UpdateTaken", 32'(br.UpdateTaken), 32'h1);
    drv(1, 32'h13C, 32'h0, 32'h6, 32'h7, 0);
    tick;
    chk("t6.p15b.UpdateTaken", 32'(br.UpdateTaken), 32'h0);
    drv(0, 0, 0, 0, 0, 0);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
